fifo_mc_mem: RTL and testbench
==============================

Name: fifo_mc_mem

Overview:
Parametrised single-clock, multi-channel FIFO buffer. It is the successor to the single-channel interface-unit FIFO memory. NUM_CH independent FIFOs share one storage array, and each channel has its own pointers, occupancy count and flags. The block keeps the direct-back-path delayed-write mode and adds a registered read port, per-channel status and almost-full/almost-empty thresholds. It sits in the interface unit between the off-chip link and the GLB/PE-array paths.

Parameters:
FIFO_WIDTH, 64, data word width in bits.
DEPTH, 16, entries per channel; power of two, >=2.
NUM_CH, 4, number of independent channels; >=1.
AFULL_LVL, DEPTH-2, almost-full is asserted when count >= AFULL_LVL.
AEMPTY_LVL, 2, almost-empty is asserted when count <= AEMPTY_LVL.
FIFO_ADDR_WIDTH, $clog2(DEPTH), derived; do not override.
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), derived.

Ports:
wclk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
direct_back_path  in  1  1 = registered (delayed) write mode; 0 = direct write.
winc  in  1  write request.
wch  in  CH_W  write channel select.
wdata  in  FIFO_WIDTH  write data.
rinc  in  1  read request.
rch  in  CH_W  read channel select.
rdata  out  FIFO_WIDTH  registered read data.
rvalid  out  1  rdata is valid this cycle.
wfull  out  NUM_CH  per-channel full, effective (includes the pending write).
rempty  out  NUM_CH  per-channel empty.
walmost_full  out  NUM_CH  per-channel count >= AFULL_LVL.
ralmost_empty  out  NUM_CH  per-channel count <= AEMPTY_LVL.
count  out  NUM_CH*(FIFO_ADDR_WIDTH+1)  per-channel occupancy; channel c occupies bits [c*(A+1) +: A+1].

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All pointers, counts, pending stage and rdata are cleared to 0, and rvalid=0.
  - Afterwards wfull=0, rempty=all 1s, ralmost_empty=all 1s, walmost_full=0 (for AFULL_LVL>0).
  - Memory contents are not reset.
- Storage: one array of NUM_CH*DEPTH words, addressed {ch, ptr[A-1:0]}. Per-channel pointers are A+1 bits; the MSB is a wrap bit and the low bits wrap naturally.
- Write acceptance: winc && !wfull[wch], with wfull sampled from current registered state. A write to a full channel is dropped with no state change.
- direct_back_path=0: an accepted write stores wdata at the same edge, and wptr[wch] and count[wch] update at that edge.
- direct_back_path=1:
  - An accepted write is captured into a one-entry pending stage (pend_v, pend_ch, pend_data).
  - The memory write, wptr and count update all occur on the next edge (commit).
  - wfull[c] = (count[c]==DEPTH) || (pend_v && pend_ch==c && count[c]==DEPTH-1).
  - Back-to-back accepted writes are allowed; a new capture and the previous commit happen on the same edge.
- Mode change with pend_v=1: the pending entry still commits on the next edge, regardless of the new mode.
- Read acceptance: rinc && !rempty[rch], using committed count. On acceptance:
  - rdata <= mem[{rch, rptr}], and rvalid=1 on the following cycle (latency 1).
  - rptr and count decrement at that edge.
- Rejected or absent read: rvalid=0 next cycle and rdata holds its previous value.
- Same-channel write commit and read on one edge: count is unchanged and both pointers advance.
- Empty channel with a simultaneous write: the read is rejected because there is no bypass; data is readable from the next cycle.
- Full channel with a simultaneous read: the write is still rejected because wfull is current-state.
- Different channels on one edge are fully independent.
- Status outputs are combinational decodes of the registered count and pending state.

Optional Feature:
FIFO_MC_ERR_FLAGS_EN. When defined, two extra outputs are added:
- ovf_err[NUM_CH]: set when winc targets a channel with wfull=1.
- udf_err[NUM_CH]: set when rinc targets a channel with rempty=1.
Both flags are sticky and cleared only by reset. When not defined, these ports and registers are absent and dropped requests are silent.

Decomposition:
Package fifo_mc_pkg holds localparams for the derived widths, the count-slice helper function, and the pending-stage struct typedef (valid, ch, data).
One sub-module, fifo_mc_ctrl, holds per-channel pointer/count/flag logic and is instantiated NUM_CH times via generate. The top level holds storage, the pending stage and the read register.

Test Plan:
1. Reset: hold reset=0 mid-traffic -> next cycle count=0, rempty=4'b1111, rvalid=0; traffic resumes cleanly after reset=1.
2. direct_back_path=0, DEPTH=16: write 16 words 0..15 to ch2 -> wfull[2]=1 after the 16th and walmost_full[2]=1 from count 14; a 17th write is dropped; reading 16 returns 0..15 with rvalid one cycle after each rinc.
3. direct_back_path=1: write 15 words to ch1, then a 16th -> wfull[1]=1 in the cycle after capture (pending) and count[1]=16 one cycle later; a 17th winc is rejected.
4. Interleave: alternate writes to ch0/ch3 with values 0xA0.. and 0xB0.., then read ch3 -> only the 0xB0 sequence is returned, in order; count[0] is unaffected.
5. Simultaneous write/read on ch0 holding 5 entries for 20 cycles -> count stays 5; pointers wrap past 15 without data corruption.
6. Read empty ch1 and write full ch2 -> rvalid=0 and no state change; with FIFO_MC_ERR_FLAGS_EN, udf_err[1]=1 and ovf_err[2]=1, both persisting until reset.

Source files
------------

// File: rtl/fifo_mc_pkg.sv
// Shared widths, pending-stage payload and count-slice helper for fifo_mc_mem.
// pend_t is sized from the default configuration below; a build that
// changes the data width or channel count updates these constants too.
package fifo_mc_pkg;

   localparam int unsigned FIFO_MC_WIDTH  = 64;
   localparam int unsigned FIFO_MC_DEPTH  = 16;
   localparam int unsigned FIFO_MC_NUM_CH = 4;
   localparam int unsigned FIFO_MC_AW     = $clog2(FIFO_MC_DEPTH);
   localparam int unsigned FIFO_MC_CH_W   = (FIFO_MC_NUM_CH > 1) ? $clog2(FIFO_MC_NUM_CH) : 1;

   // One-entry delayed-write stage
   typedef struct packed {
      logic                     valid;
      logic [FIFO_MC_CH_W-1:0]  ch;
      logic [FIFO_MC_WIDTH-1:0] data;
   } pend_t;

   // LSB of channel ch inside the packed per-channel count bus
   function automatic int unsigned cnt_lsb(input int unsigned ch, input int unsigned aw);
      return ch * (aw + 1);
   endfunction

endpackage

// File: rtl/fifo_mc_ctrl.sv
// Per-channel pointer, occupancy and status logic for fifo_mc_mem.
// Optional sticky error flags under FIFO_MC_ERR_FLAGS_EN.
module fifo_mc_ctrl #(
   parameter  int unsigned DEPTH      = 16,
   parameter  int unsigned AFULL_LVL  = DEPTH - 2,
   parameter  int unsigned AEMPTY_LVL = 2,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    wr_cnt,     // words committed this edge (0..2)
   input  logic          rd,         // accepted read this edge
   input  logic          pend_here,  // pending stage targets this channel
   output logic [AW:0]   wptr,
   output logic [AW:0]   rptr,
   output logic [AW:0]   count,
   output logic          wfull_c,
   output logic          rempty_c,
   output logic          walmost_full_c,
   output logic          ralmost_empty_c
`ifdef FIFO_MC_ERR_FLAGS_EN
   ,
   input  logic          winc_hit,
   input  logic          rinc_hit,
   output logic          ovf_err,
   output logic          udf_err
`endif
);

   localparam int unsigned CW = AW + 1;

   logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;

   // Pointer and occupancy next state
   always_comb begin
      wptr_d = wptr_q + CW'(wr_cnt);
      rptr_d = rptr_q + CW'(rd);
      cnt_d  = cnt_q + CW'(wr_cnt) - CW'(rd);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign wptr  = wptr_q;
   assign rptr  = rptr_q;
   assign count = cnt_q;

   // Full counts the word sitting in the pending stage
   assign wfull_c         = (cnt_q == CW'(DEPTH)) || (pend_here && (cnt_q == CW'(DEPTH - 1)));
   assign rempty_c        = (cnt_q == '0);
   assign walmost_full_c  = (cnt_q >= CW'(AFULL_LVL));
   assign ralmost_empty_c = (cnt_q <= CW'(AEMPTY_LVL));

`ifdef FIFO_MC_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   // Sticky overflow/underflow detection
   always_comb begin
      ovf_d = ovf_q | (winc_hit & wfull_c);
      udf_d = udf_q | (rinc_hit & rempty_c);
   end

   // Error flag registers, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf_err = ovf_q;
   assign udf_err = udf_q;
`endif

endmodule

// File: rtl/fifo_mc_mem.sv
// Multi-channel FIFO: shared storage, delayed-write stage and registered read port.
// Define FIFO_MC_ERR_FLAGS_EN to add sticky ovf_err/udf_err outputs.
module fifo_mc_mem
   import fifo_mc_pkg::*;
#(
   parameter  int unsigned FIFO_WIDTH      = FIFO_MC_WIDTH,
   parameter  int unsigned DEPTH           = FIFO_MC_DEPTH,
   parameter  int unsigned NUM_CH          = FIFO_MC_NUM_CH,
   parameter  int unsigned AFULL_LVL       = DEPTH - 2,
   parameter  int unsigned AEMPTY_LVL      = 2,
   localparam int unsigned FIFO_ADDR_WIDTH = $clog2(DEPTH),
   localparam int unsigned CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                                 wclk,
   input  logic                                 reset,
   input  logic                                 direct_back_path,
   input  logic                                 winc,
   input  logic [CH_W-1:0]                      wch,
   input  logic [FIFO_WIDTH-1:0]                wdata,
   input  logic                                 rinc,
   input  logic [CH_W-1:0]                      rch,
   output logic [FIFO_WIDTH-1:0]                rdata,
   output logic                                 rvalid,
   output logic [NUM_CH-1:0]                    wfull,
   output logic [NUM_CH-1:0]                    rempty,
   output logic [NUM_CH-1:0]                    walmost_full,
   output logic [NUM_CH-1:0]                    ralmost_empty,
   output logic [NUM_CH*(FIFO_ADDR_WIDTH+1)-1:0] count
`ifdef FIFO_MC_ERR_FLAGS_EN
   ,
   output logic [NUM_CH-1:0]                    ovf_err,
   output logic [NUM_CH-1:0]                    udf_err
`endif
);

   localparam int unsigned A     = FIFO_ADDR_WIDTH;
   localparam int unsigned CW    = A + 1;
   localparam int unsigned WORDS = NUM_CH * DEPTH;

   logic [FIFO_WIDTH-1:0] mem_q [WORDS];
   pend_t                 pend_q, pend_d;
   logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic [CW-1:0]         wptr [NUM_CH];
   logic [CW-1:0]         rptr [NUM_CH];
   logic [CW-1:0]         cnt  [NUM_CH];
   logic                  wr_acc, rd_acc, dir_wr;
   logic [A-1:0]          dir_ptr;

   assign wr_acc = winc && !wfull[wch];
   assign rd_acc = rinc && !rempty[rch];
   assign dir_wr = wr_acc && !direct_back_path;

   // Pending capture, read data selection, direct-write slot
   always_comb begin
      pend_d.valid = wr_acc && direct_back_path;
      pend_d.ch    = FIFO_MC_CH_W'(wch);
      pend_d.data  = FIFO_MC_WIDTH'(wdata);
      rvalid_d     = rd_acc;
      rdata_d      = rd_acc ? mem_q[{rch, rptr[rch][A-1:0]}] : rdata_q;
      // An older pending word to the same channel takes the current slot
      dir_ptr      = wptr[wch][A-1:0] + A'(pend_q.valid && (pend_q.ch == FIFO_MC_CH_W'(wch)));
   end

   // Pending stage and read port registers
   always_ff @(posedge wclk or negedge reset) begin
      if (!reset) begin
         pend_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Storage writes: pending commit and direct write may land on one edge
   always_ff @(posedge wclk) begin
      if (pend_q.valid)
         mem_q[{pend_q.ch, wptr[pend_q.ch][A-1:0]}] <= pend_q.data;
      if (dir_wr)
         mem_q[{wch, dir_ptr}] <= wdata;
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;

   // Per-channel control
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic pend_here, direct_here, rd_here;

      assign pend_here   = pend_q.valid && (pend_q.ch == FIFO_MC_CH_W'(c));
      assign direct_here = dir_wr && (wch == CH_W'(c));
      assign rd_here     = rd_acc && (rch == CH_W'(c));

`ifdef FIFO_MC_ERR_FLAGS_EN
      fifo_mc_ctrl #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)) u_ctrl (
         .clk             (wclk),
         .rst_n           (reset),
         .wr_cnt          ({pend_here & direct_here, pend_here ^ direct_here}),
         .rd              (rd_here),
         .pend_here       (pend_here),
         .wptr            (wptr[c]),
         .rptr            (rptr[c]),
         .count           (cnt[c]),
         .wfull_c         (wfull[c]),
         .rempty_c        (rempty[c]),
         .walmost_full_c  (walmost_full[c]),
         .ralmost_empty_c (ralmost_empty[c]),
         .winc_hit        (winc && (wch == CH_W'(c))),
         .rinc_hit        (rinc && (rch == CH_W'(c))),
         .ovf_err         (ovf_err[c]),
         .udf_err         (udf_err[c])
      );
`else
      fifo_mc_ctrl #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)) u_ctrl (
         .clk             (wclk),
         .rst_n           (reset),
         .wr_cnt          ({pend_here & direct_here, pend_here ^ direct_here}),
         .rd              (rd_here),
         .pend_here       (pend_here),
         .wptr            (wptr[c]),
         .rptr            (rptr[c]),
         .count           (cnt[c]),
         .wfull_c         (wfull[c]),
         .rempty_c        (rempty[c]),
         .walmost_full_c  (walmost_full[c]),
         .ralmost_empty_c (ralmost_empty[c])
      );
`endif

      assign count[cnt_lsb(c, A) +: CW] = cnt[c];
   end

endmodule

// File: tb/tb_fifo_mc_mem.sv
// Directed bench for fifo_mc_mem: vector table plus multi-cycle sequences.
module tb_fifo_mc_mem;

   logic        wclk = 1'b0;
   logic        reset;
   logic        direct_back_path;
   logic        winc;
   logic [1:0]  wch;
   logic [63:0] wdata;
   logic        rinc;
   logic [1:0]  rch;
   logic [63:0] rdata;
   logic        rvalid;
   logic [3:0]  wfull, rempty, walmost_full, ralmost_empty;
   logic [19:0] count;
`ifdef FIFO_MC_ERR_FLAGS_EN
   logic [3:0]  ovf_err, udf_err;
`endif

   always #5 wclk = ~wclk;

   fifo_mc_mem dut (
      .wclk             (wclk),
      .reset            (reset),
      .direct_back_path (direct_back_path),
      .winc             (winc),
      .wch              (wch),
      .wdata            (wdata),
      .rinc             (rinc),
      .rch              (rch),
      .rdata            (rdata),
      .rvalid           (rvalid),
      .wfull            (wfull),
      .rempty           (rempty),
      .walmost_full     (walmost_full),
      .ralmost_empty    (ralmost_empty),
      .count            (count)
`ifdef FIFO_MC_ERR_FLAGS_EN
      ,
      .ovf_err          (ovf_err),
      .udf_err          (udf_err)
`endif
   );

   typedef struct {
      logic        dbp;
      logic        wi;
      logic [1:0]  wc;
      logic [63:0] wd;
      logic        ri;
      logic [1:0]  rc;
      logic        ev;   // expected rvalid
      logic [63:0] ed;   // expected rdata
      logic [19:0] ec;   // expected packed counts
   } vec_t;

   vec_t        tv [13];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] q [$];
   logic [63:0] exp_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic drive(input logic dbp, input logic wi, input logic [1:0] wc,
                        input logic [63:0] wd, input logic ri, input logic [1:0] rc);
      direct_back_path = dbp;
      winc  = wi;
      wch   = wc;
      wdata = wd;
      rinc  = ri;
      rch   = rc;
   endtask

   function automatic logic [19:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
   endfunction

   function automatic logic [4:0] cnt_of(input int c);
      return count[c*5 +: 5];
   endfunction

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"},  64'(count), 64'h0);
      chk({tag, "_rempty"}, 64'(rempty), 64'hF);
      chk({tag, "_ralmost_empty"}, 64'(ralmost_empty), 64'hF);
      chk({tag, "_wfull"},  64'(wfull), 64'h0);
      chk({tag, "_walmost_full"}, 64'(walmost_full), 64'h0);
      chk({tag, "_rvalid"}, 64'(rvalid), 64'h0);
      chk({tag, "_rdata"},  rdata, 64'h0);
   endtask

   initial begin
      tv[0]  = '{1'b0, 1'b1, 2'd0, 64'h11, 1'b0, 2'd0, 1'b0, 64'h0,  pk(1,0,0,0)};
      tv[1]  = '{1'b0, 1'b1, 2'd1, 64'h22, 1'b0, 2'd0, 1'b0, 64'h0,  pk(1,1,0,0)};
      tv[2]  = '{1'b0, 1'b0, 2'd0, 64'h0,  1'b1, 2'd0, 1'b1, 64'h11, pk(0,1,0,0)};
      tv[3]  = '{1'b0, 1'b0, 2'd0, 64'h0,  1'b1, 2'd0, 1'b0, 64'h11, pk(0,1,0,0)};
      tv[4]  = '{1'b0, 1'b1, 2'd0, 64'h33, 1'b1, 2'd1, 1'b1, 64'h22, pk(1,0,0,0)};
      tv[5]  = '{1'b1, 1'b1, 2'd3, 64'h44, 1'b0, 2'd0, 1'b0, 64'h22, pk(1,0,0,0)};
      tv[6]  = '{1'b1, 1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 1'b0, 64'h22, pk(1,0,0,1)};
      tv[7]  = '{1'b1, 1'b0, 2'd0, 64'h0,  1'b1, 2'd3, 1'b1, 64'h44, pk(1,0,0,0)};
      tv[8]  = '{1'b1, 1'b1, 2'd3, 64'h55, 1'b1, 2'd3, 1'b0, 64'h44, pk(1,0,0,0)};
      tv[9]  = '{1'b0, 1'b1, 2'd3, 64'h66, 1'b0, 2'd0, 1'b0, 64'h44, pk(1,0,0,2)};
      tv[10] = '{1'b0, 1'b0, 2'd0, 64'h0,  1'b1, 2'd3, 1'b1, 64'h55, pk(1,0,0,1)};
      tv[11] = '{1'b0, 1'b0, 2'd0, 64'h0,  1'b1, 2'd3, 1'b1, 64'h66, pk(1,0,0,0)};
      tv[12] = '{1'b0, 1'b0, 2'd0, 64'h0,  1'b1, 2'd0, 1'b1, 64'h33, pk(0,0,0,0)};

      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
      reset = 1'b0;
      tick();
      tick();
      chk_reset_state("rst0");
      reset = 1'b1;
      tick();

      // Vector table: basic writes/reads, holds, delayed mode, mode switch
      for (int i = 0; i < 13; i++) begin
         drive(tv[i].dbp, tv[i].wi, tv[i].wc, tv[i].wd, tv[i].ri, tv[i].rc);
         tick();
         chk($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tv[i].ev));
         chk($sformatf("tbl%0d_rdata", i), rdata, tv[i].ed);
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tv[i].ec));
         for (int c = 0; c < 4; c++)
            chk($sformatf("tbl%0d_rempty%0d", i, c), 64'(rempty[c]),
                64'(tv[i].ec[c*5 +: 5] == 5'd0));
      end

      // Direct mode fill/drain of ch2 with threshold flags
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 2'd2, 64'(i), 1'b0, 2'd0);
         tick();
         chk($sformatf("fill2_cnt%0d", i), 64'(cnt_of(2)), 64'(i + 1));
         chk($sformatf("fill2_afull%0d", i), 64'(walmost_full[2]), 64'((i + 1) >= 14));
         chk($sformatf("fill2_full%0d", i), 64'(wfull[2]), 64'((i + 1) == 16));
         chk($sformatf("fill2_aempty%0d", i), 64'(ralmost_empty[2]), 64'((i + 1) <= 2));
      end
      drive(1'b0, 1'b1, 2'd2, 64'h99, 1'b0, 2'd0);
      tick();
      chk("fill2_drop_cnt", 64'(cnt_of(2)), 64'd16);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
         tick();
         chk($sformatf("drain2_rvalid%0d", i), 64'(rvalid), 64'd1);
         chk($sformatf("drain2_rdata%0d", i), rdata, 64'(i));
         chk($sformatf("drain2_cnt%0d", i), 64'(cnt_of(2)), 64'(15 - i));
      end
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
      tick();
      chk("drain2_idle_rvalid", 64'(rvalid), 64'd0);

      // Delayed mode fill of ch1: count lags capture, full includes pending
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 2'd1, 64'h100 + 64'(i), 1'b0, 2'd0);
         tick();
         chk($sformatf("dly1_cnt%0d", i), 64'(cnt_of(1)), 64'(i));
         chk($sformatf("dly1_full%0d", i), 64'(wfull[1]), 64'(i == 15));
      end
      drive(1'b1, 1'b1, 2'd1, 64'h1FF, 1'b0, 2'd0);
      tick();
      chk("dly1_cnt16", 64'(cnt_of(1)), 64'd16);
      chk("dly1_full16", 64'(wfull[1]), 64'd1);
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
      tick();
      chk("dly1_drop_cnt", 64'(cnt_of(1)), 64'd16);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd1);
         tick();
         chk($sformatf("dly1_rdata%0d", i), rdata, 64'h100 + 64'(i));
      end
      chk("dly1_empty_cnt", 64'(cnt_of(1)), 64'd0);

      // Interleaved ch0/ch3 writes, then read ch3 only
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 2'd0, 64'hA0 + 64'(i), 1'b0, 2'd0);
         tick();
         drive(1'b0, 1'b1, 2'd3, 64'hB0 + 64'(i), 1'b0, 2'd0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd3);
         tick();
         chk($sformatf("ilv3_rdata%0d", i), rdata, 64'hB0 + 64'(i));
         chk($sformatf("ilv3_cnt0_%0d", i), 64'(cnt_of(0)), 64'd4);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
         tick();
         chk($sformatf("ilv0_rdata%0d", i), rdata, 64'hA0 + 64'(i));
      end

      // Steady simultaneous write/read on ch0 with 5 entries, wrapping pointers
      q = {};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 2'd0, 64'hC0 + 64'(i), 1'b0, 2'd0);
         q.push_back(64'hC0 + 64'(i));
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 2'd0, 64'hC5 + 64'(i), 1'b1, 2'd0);
         exp_d = q.pop_front();
         q.push_back(64'hC5 + 64'(i));
         tick();
         chk($sformatf("rw0_rvalid%0d", i), 64'(rvalid), 64'd1);
         chk($sformatf("rw0_rdata%0d", i), rdata, exp_d);
         chk($sformatf("rw0_cnt%0d", i), 64'(cnt_of(0)), 64'd5);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
         exp_d = q.pop_front();
         tick();
         chk($sformatf("rw0_drain%0d", i), rdata, exp_d);
      end

      // Read empty ch1, write full ch2
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd1);
      tick();
      chk("udf1_rvalid", 64'(rvalid), 64'd0);
      chk("udf1_count", 64'(count), 64'h0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 2'd2, 64'h200 + 64'(i), 1'b0, 2'd0);
         tick();
      end
      drive(1'b0, 1'b1, 2'd2, 64'h2FF, 1'b0, 2'd0);
      tick();
      chk("ovf2_count", 64'(count), 64'(pk(0,0,16,0)));
      chk("ovf2_full", 64'(wfull), 64'h4);
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
      tick();
      chk("ovf2_first_rdata", rdata, 64'h200);
`ifdef FIFO_MC_ERR_FLAGS_EN
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
      tick();
      chk("udf_err1", 64'(udf_err[1]), 64'd1);
      chk("ovf_err2", 64'(ovf_err[2]), 64'd1);
`endif

      // Reset in the middle of delayed-mode traffic
      drive(1'b1, 1'b1, 2'd0, 64'h5A, 1'b1, 2'd2);
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk_reset_state("rst1");
`ifdef FIFO_MC_ERR_FLAGS_EN
      chk("rst1_ovf_err", 64'(ovf_err), 64'h0);
      chk("rst1_udf_err", 64'(udf_err), 64'h0);
`endif
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("rst1_no_pending_commit", 64'(count), 64'h0);
      drive(1'b0, 1'b1, 2'd0, 64'h77, 1'b0, 2'd0);
      tick();
      chk("post_rst_cnt", 64'(cnt_of(0)), 64'd1);
      drive(1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
      tick();
      chk("post_rst_rvalid", 64'(rvalid), 64'd1);
      chk("post_rst_rdata", rdata, 64'h77);
      chk("post_rst_empty", 64'(rempty), 64'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
